// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack port between fetch_stage (master) and imem (slave).
interface fetch_stage_if #(
    parameter int unsigned XLEN = 64
);
    logic            ImemReq;
    logic [XLEN-1:0] ImemAddr;
    logic [31:0]     ImemRdata;
    logic            ImemAck;

    modport master (output ImemReq, ImemAddr, input ImemRdata, ImemAck);
    modport slave  (input ImemReq, ImemAddr, output ImemRdata, ImemAck);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, one outstanding imem request and
// the IF/ID register feeding decode; honours redirect, flush and stall.
module fetch_stage #(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSF,
    input  logic [XLEN-1:0] PCTargetD,
    input  logic            StallD,
    input  logic            FlushD,
    fetch_stage_if.master   imem,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D
);

    typedef enum logic [1:0] {REQ, DROP, HOLD} stateT;

    stateT           state, stateNext;
    logic [XLEN-1:0] PCF, PCFNext;
    logic [XLEN-1:0] StaleAddr, StaleAddrNext;
    logic [XLEN-1:0] HoldPC, HoldPCNext;
    logic [31:0]     HoldInstr, HoldInstrNext;
    logic [31:0]     InstrDNext;
    logic [XLEN-1:0] PCDNext, PCPlus4DNext;
    logic [XLEN-1:0] redirectPC, PCFPlus4;
    logic            loadBubble, loadFetch, loadHold;

    assign redirectPC = PCTargetD & ~XLEN'(3);
    assign PCFPlus4   = PCF + XLEN'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= REQ;
            PCF       <= RESET_PC;
            StaleAddr <= '0;
            HoldInstr <= '0;
            HoldPC    <= '0;
            InstrD    <= NOP_INSTR;
            PCD       <= '0;
            PCPlus4D  <= '0;
        end else begin
            state     <= stateNext;
            PCF       <= PCFNext;
            StaleAddr <= StaleAddrNext;
            HoldInstr <= HoldInstrNext;
            HoldPC    <= HoldPCNext;
            InstrD    <= InstrDNext;
            PCD       <= PCDNext;
            PCPlus4D  <= PCPlus4DNext;
        end
    end

    always_comb begin
        stateNext     = state;
        PCFNext       = PCF;
        StaleAddrNext = StaleAddr;
        HoldInstrNext = HoldInstr;
        HoldPCNext    = HoldPC;
        loadBubble    = 1'b0;
        loadFetch     = 1'b0;
        loadHold      = 1'b0;

        case (state)
            REQ: begin
                if (PCSF) begin
                    PCFNext    = redirectPC;
                    loadBubble = 1'b1;
                    // Request still in flight: remember its address so it can be drained.
                    if (!imem.ImemAck) begin
                        StaleAddrNext = PCF;
                        stateNext     = DROP;
                    end
                end else if (imem.ImemAck) begin
                    PCFNext = PCFPlus4;
                    if (StallD) begin
                        HoldInstrNext = imem.ImemRdata;
                        HoldPCNext    = PCF;
                        loadBubble    = FlushD;
                        stateNext     = HOLD;
                    end else begin
                        loadBubble = FlushD;
                        loadFetch  = !FlushD;
                    end
                end else begin
                    loadBubble = !StallD || FlushD;
                end
            end
            DROP: begin
                loadBubble = !StallD || FlushD;
                if (PCSF)
                    PCFNext = redirectPC;
                if (imem.ImemAck)
                    stateNext = REQ;
            end
            HOLD: begin
                if (PCSF) begin
                    PCFNext    = redirectPC;
                    loadBubble = 1'b1;
                    stateNext  = REQ;
                end else if (!StallD) begin
                    loadBubble = FlushD;
                    loadHold   = !FlushD;
                    stateNext  = REQ;
                end else begin
                    loadBubble = FlushD;
                end
            end
            default: stateNext = REQ;
        endcase

        InstrDNext   = InstrD;
        PCDNext      = PCD;
        PCPlus4DNext = PCPlus4D;
        if (loadBubble) begin
            InstrDNext   = NOP_INSTR;
            PCDNext      = '0;
            PCPlus4DNext = '0;
        end else if (loadFetch) begin
            InstrDNext   = imem.ImemRdata;
            PCDNext      = PCF;
            PCPlus4DNext = PCFPlus4;
        end else if (loadHold) begin
            InstrDNext   = HoldInstr;
            PCDNext      = HoldPC;
            PCPlus4DNext = HoldPC + XLEN'(4);
        end
    end

    always_comb begin
        imem.ImemReq  = (state != HOLD);
        imem.ImemAddr = (state == DROP) ? StaleAddr : PCF;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 64-bit RISC-V pipeline, directly upstream of decode_stage.
- Owns the fetch PC and drives a single-outstanding request/ack instruction-memory port.
- Owns the IF/ID pipeline register that produces InstrD/PCD/PCPlus4D.
- Consumes decode's branch/jump redirect (PCSF, PCTargetD) and the hazard unit's StallD/FlushD.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h0, first fetch address after reset.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- PCSF  input  1  redirect from decode: take PCTargetD.
- PCTargetD  input  XLEN  redirect target from decode.
- StallD  input  1  hold IF/ID register and fetch PC (load-use stall).
- FlushD  input  1  load bubble into IF/ID.
- ImemReq  output  1  instruction request valid.
- ImemAddr  output  XLEN  request address; stable while ImemReq=1 and no ack.
- ImemRdata  input  32  instruction data, valid when ImemAck=1.
- ImemAck  input  1  request completes this cycle; may be high in the request's first cycle.
- InstrD  output  32  IF/ID instruction.
- PCD  output  XLEN  IF/ID PC.
- PCPlus4D  output  XLEN  IF/ID PC+4.

Behaviour:
- Reset (rst=0, async): PCF=RESET_PC, state=REQ, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, hold buffer cleared.
- Reset deassertion: first request issues the same cycle. Reset mid-request abandons it; the memory must tolerate this.
- Internal state: PCF, StaleAddr, hold buffer {HoldInstr, HoldPC}, FSM {REQ, DROP, HOLD}.
- Redirects: PCTargetD[1:0] forced to 00 when loaded. PC+4 wraps modulo 2^XLEN.
- Priority per cycle: PCSF > FlushD > StallD. "Bubble" means InstrD=NOP_INSTR, PCD=0, PCPlus4D=0.
- State REQ: ImemReq=1, ImemAddr=PCF.
  - PCSF & ImemAck: data discarded; PCF<=target; IF/ID<=bubble; stay REQ.
  - PCSF & !ImemAck: StaleAddr<=PCF; PCF<=target; IF/ID<=bubble; ->DROP.
  - ImemAck & !StallD: IF/ID<={ImemRdata, PCF, PCF+4}, or bubble if FlushD; PCF<=PCF+4.
  - ImemAck & StallD: hold buffer<={ImemRdata, PCF}; PCF<=PCF+4; IF/ID held (bubble if FlushD); ->HOLD.
  - !ImemAck: PCF held; IF/ID<=bubble if !StallD or FlushD, else held.
- State DROP: ImemReq=1, ImemAddr=StaleAddr.
  - IF/ID<=bubble unless StallD & !FlushD (then held).
  - PCSF: PCF<=target; latest redirect wins.
  - ImemAck: data discarded; ->REQ.
- State HOLD: ImemReq=0.
  - PCSF: buffer discarded; PCF<=target; IF/ID<=bubble; ->REQ.
  - !StallD: IF/ID<={HoldInstr, HoldPC, HoldPC+4}, or bubble if FlushD; ->REQ.
  - Otherwise: stay HOLD.
- Latency: zero-wait memory gives one instruction per cycle. An instruction fetched in cycle n appears on InstrD after edge n.
- Redirect penalty: one bubble with zero-wait memory.
- At most one request outstanding. Every ack is consumed or discarded exactly once.

Test Plan:
- Reset then zero-wait memory, ack=1 always, RESET_PC=0 -> ImemAddr 0,4,8,...; InstrD/PCD/PCPlus4D follow one cycle later. InstrD=NOP_INSTR and PCD=0 until the first edge after reset release.
- Ack delayed 2 cycles at PC=0x40 -> ImemAddr stays 0x40 for 3 cycles; 2 bubbles into decode; then InstrD=data, PCD=0x40, PCPlus4D=0x44.
- PCSF=1, PCTargetD=0x103 during pending fetch of 0x48 -> ->DROP; ImemAddr stays 0x48 until ack; data dropped. Next request is 0x100; a bubble appears in decode; no instruction from 0x48 reaches InstrD.
- StallD=1 for 3 cycles while ack=1 -> IF/ID frozen; one ImemReq pulse buffered, then ImemReq=0. On release, the buffered instruction issues first, followed by PC+4 with no loss or duplication.
- PCSF and FlushD together with StallD=1 in HOLD -> buffer discarded; bubble loaded; fetch resumes at target.
- PC=64'hFFFF_FFFF_FFFF_FFFC fetched -> PCPlus4D=0 and next ImemAddr=0. Assert rst low mid-DROP -> all outputs at reset values immediately, asynchronously.
